// File: rtl/processor_status_pkg.sv
// Package: processor_status_pkg
//   Bit positions of the 6502 processor status register (P) and a helper
//   that assembles the architectural byte from the individual flags.
//   Shared with the decode and stack logic so every block agrees on the layout.
package processor_status_pkg;

  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_I = 2;
  localparam int P_D = 3;
  localparam int P_B = 4;
  localparam int P_U = 5;
  localparam int P_V = 6;
  localparam int P_N = 7;

  // Bit 5 (U) is hard-wired to 1; B is not stored and is supplied by the caller.
  function automatic logic [7:0] pack_p(input logic n, input logic v, input logic b,
                                        input logic d, input logic i, input logic z,
                                        input logic c);
    logic [7:0] p;
    p      = 8'h00;
    p[P_N] = n;
    p[P_V] = v;
    p[P_U] = 1'b1;
    p[P_B] = b;
    p[P_D] = d;
    p[P_I] = i;
    p[P_Z] = z;
    p[P_C] = c;
    return p;
  endfunction

endpackage

// File: rtl/processor_status_so_edge_detect.sv
// Module: so_edge_detect
//   Brings the asynchronous set-overflow pin into the clock domain through a
//   2-flop synchronizer and emits a one-cycle pulse on each 1->0 transition.
//   All flops reset to 1 so a pin that is already low at reset release does
//   not look like a fresh edge until it has been seen high.
// Ports:
//   i_clk      clock
//   i_reset_n  asynchronous active-low reset
//   i_so_n     set-overflow pin (active low, asynchronous)
//   o_fall     one-cycle pulse: synchronized pin fell since last cycle
module so_edge_detect (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_so_n,
  output logic o_fall
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_so_n;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_fall = r_prev & ~r_sync2;

endmodule

// File: rtl/processor_status.sv
// Module: processor_status
//   6502 processor status register P. Six stored flags (C,Z,I,D,V,N), bit 5
//   constant 1, B taken live from i_b. Flags load from the internal data bus,
//   from IR bit 5 (flag instructions) or from the ALU carry/overflow outputs.
//   P is driven onto the data bus for PHP/BRK/IRQ/NMI pushes.
// Optional feature: PSR_SO_PIN_EN enables the set-overflow pin (i_so_n).
//   Without it the pin is ignored and no synchronizer flops are built.
// Ports:
//   i_clk, i_reset_n      clock, asynchronous active-low reset
//   i_db[7:0]             internal data bus (flag load source, zero detect)
//   i_ir5                 IR bit 5 (set/clear value for SEx/CLx)
//   i_acr, i_avr          ALU carry / overflow
//   i_*_<flag>            load strobes, named <source>_<flag>
//   i_p_db                request P onto the data bus
//   i_b                   B bit presented on o_p / o_db
//   i_so_n                set-overflow pin
//   o_p[7:0]              live flag view {N,V,1,B,D,I,Z,C}
//   o_db[7:0], o_db_en    P for the data bus (zero when not requested), enable
module processor_status
  import processor_status_pkg::*;
#(
  parameter logic RESET_I = 1'b1,
  parameter logic RESET_D = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [7:0] i_db,
  input  logic       i_ir5,
  input  logic       i_acr,
  input  logic       i_avr,
  input  logic       i_db0_c,
  input  logic       i_ir5_c,
  input  logic       i_acr_c,
  input  logic       i_db1_z,
  input  logic       i_dbz_z,
  input  logic       i_db2_i,
  input  logic       i_ir5_i,
  input  logic       i_db3_d,
  input  logic       i_ir5_d,
  input  logic       i_db6_v,
  input  logic       i_avr_v,
  input  logic       i_0_v,
  input  logic       i_db7_n,
  input  logic       i_p_db,
  input  logic       i_b,
  input  logic       i_so_n,
  output logic [7:0] o_p,
  output logic [7:0] o_db,
  output logic       o_db_en
);

  logic r_c, r_z, r_i, r_d, r_v, r_n;
  logic w_so_set;
  logic [7:0] w_p;

`ifdef PSR_SO_PIN_EN
  so_edge_detect u_so_edge_detect (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_so_n    (i_so_n),
    .o_fall    (w_so_set)
  );
`else
  logic w_unused_so_n;
  assign w_unused_so_n = i_so_n;
  assign w_so_set      = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_c <= 1'b0;
      r_z <= 1'b0;
      r_i <= RESET_I;
      r_d <= RESET_D;
      r_v <= 1'b0;
      r_n <= 1'b0;
    end else begin
      if (i_db0_c)      r_c <= i_db[P_C];
      else if (i_ir5_c) r_c <= i_ir5;
      else if (i_acr_c) r_c <= i_acr;

      if (i_db1_z)      r_z <= i_db[P_Z];
      else if (i_dbz_z) r_z <= (i_db == 8'h00);

      if (i_db2_i)      r_i <= i_db[P_I];
      else if (i_ir5_i) r_i <= i_ir5;

      if (i_db3_d)      r_d <= i_db[P_D];
      else if (i_ir5_d) r_d <= i_ir5;

      // A set-overflow edge beats every other V source, including CLV.
      if (w_so_set)     r_v <= 1'b1;
      else if (i_db6_v) r_v <= i_db[P_V];
      else if (i_avr_v) r_v <= i_avr;
      else if (i_0_v)   r_v <= 1'b0;

      if (i_db7_n)      r_n <= i_db[P_N];
    end
  end

  // Built from the flops only, so driving P onto the bus while a flag loads
  // from the bus presents the pre-update value and forms no loop.
  assign w_p     = pack_p(r_n, r_v, i_b, r_d, r_i, r_z, r_c);
  assign o_p     = w_p;
  assign o_db    = i_p_db ? w_p : 8'h00;
  assign o_db_en = i_p_db;

endmodule
